ahb_apb_bridge_nslv: RTL and testbench

AHB_APB_BRIDGE_NSLV -- requirements
Module: ahb_apb_bridge_nslv

---
 rtl/ahb_apb_pkg.sv | 47 ++++
 rtl/apb_slave_decoder.sv | 41 ++++
 rtl/ahb_apb_bridge_nslv.sv | 230 +++++++++++++++++++++++
 tb/tb_ahb_apb_bridge_nslv.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge.
//   state_e     : bridge FSM states
//   HTRANS_*    : AHB transfer-type encodings
//   HSIZE_*     : AHB transfer-size encodings
//   pstrb_gen() : byte-lane strobe from transfer size and low address bits
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // Returns an 8-lane strobe; a 32-bit bus uses only the low 4 lanes and
    // ignores address bit 2. Sizes at or above the bus width enable all lanes.
    function automatic logic [7:0] pstrb_gen(input logic [2:0] hsize,
                                             input logic [2:0] addr_lo,
                                             input logic       wide);
        logic [2:0] lo;
        logic [7:0] strb;
        lo = wide ? addr_lo : {1'b0, addr_lo[1:0]};
        case (hsize)
            HSIZE_BYTE:  strb = 8'h01 << lo;
            HSIZE_HALF:  strb = 8'h03 << {lo[2:1], 1'b0};
            HSIZE_WORD:  strb = 8'h0F << {lo[2], 2'b00};
            HSIZE_DWORD: strb = 8'hFF;
            default:     strb = 8'hFF;
        endcase
        if (!wide) begin
            strb = strb & 8'h0F;
        end
        return strb;
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Address decoder for the AHB-to-APB bridge.
// Slave i is selected when addr_i[DEC_HI:DEC_LO] == BASE_ID + i.
//   addr_i : AHB address
//   idx_o  : index of the selected slave (0 on a miss)
//   hit_o  : 1 when the address maps to one of the NSLV slaves
module apb_slave_decoder
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV    = 2,
    parameter int unsigned DEC_HI  = 31,
    parameter int unsigned DEC_LO  = 24,
    parameter int unsigned BASE_ID = 32'hF0,
    parameter int unsigned IDX_W   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             hit_o
);

    localparam int unsigned FieldW = DEC_HI - DEC_LO + 1;

    logic [FieldW-1:0] field;
    logic [31:0]       field_ext;
    logic              unused_addr;

    assign field       = addr_i[DEC_HI:DEC_LO];
    assign field_ext   = 32'(field);
    assign unused_addr = ^addr_i;

    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (field_ext == BASE_ID + i) begin
                idx_o = IDX_W'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite slave to APB master bridge driving NSLV APB slaves.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that sees
// pready low for TIMEOUT_CYC cycles (answered with an AHB ERROR response).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   io_ahb_*  (inputs)  : AHB address/control/write data, hsel, hreadyin
//   io_ahb_hrdata/hreadyout/hresp : AHB read data and response
//   io_apb_paddr/pwrite/penable/pwdata/pstrb/pprot : shared APB request
//   io_apb_psel         : one-hot slave select
//   io_apb_prdata/pready/pslverr : per-slave APB responses
module ahb_apb_bridge_nslv
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV        = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEC_HI      = 31,
    parameter int unsigned DEC_LO      = 24,
    parameter int unsigned BASE_ID     = 32'hF0,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            io_ahb_haddr,
    input  logic                   io_ahb_hwrite,
    input  logic [2:0]             io_ahb_hsize,
    input  logic [1:0]             io_ahb_htrans,
    input  logic [3:0]             io_ahb_hprot,
    input  logic [DATA_W-1:0]      io_ahb_hwdata,
    input  logic                   io_ahb_hsel,
    input  logic                   io_ahb_hreadyin,
    output logic [DATA_W-1:0]      io_ahb_hrdata,
    output logic                   io_ahb_hreadyout,
    output logic                   io_ahb_hresp,
    output logic [31:0]            io_apb_paddr,
    output logic                   io_apb_pwrite,
    output logic                   io_apb_penable,
    output logic [DATA_W-1:0]      io_apb_pwdata,
    output logic [DATA_W/8-1:0]    io_apb_pstrb,
    output logic [2:0]             io_apb_pprot,
    output logic [NSLV-1:0]        io_apb_psel,
    input  logic [NSLV*DATA_W-1:0] io_apb_prdata,
    input  logic [NSLV-1:0]        io_apb_pready,
    input  logic [NSLV-1:0]        io_apb_pslverr
);

    localparam int unsigned IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic [31:0]       haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [1:0]        hprot_q, hprot_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              miss_q, miss_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;

    logic [IDX_W-1:0]  dec_idx;
    logic              dec_hit;
    logic              pready_m, pslverr_m;
    logic [DATA_W-1:0] prdata_m;
    logic              hreadyout;
    logic              xfer;
    logic              timeout;
    state_e            next_xfer;
    logic [7:0]        strb_all;
    logic              unused_strb;
    logic              unused_hprot;

    apb_slave_decoder #(
        .NSLV    (NSLV),
        .DEC_HI  (DEC_HI),
        .DEC_LO  (DEC_LO),
        .BASE_ID (BASE_ID),
        .IDX_W   (IDX_W)
    ) u_decoder (
        .addr_i (io_ahb_haddr),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // Slave response mux, steered by the index captured with the address.
    always_comb begin
        pready_m  = 1'b0;
        pslverr_m = 1'b0;
        prdata_m  = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_m  = io_apb_pready[i];
                pslverr_m = io_apb_pslverr[i];
                prdata_m  = io_apb_prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        case (state_q)
            StIdle, StErr2: hreadyout = 1'b1;
            StAccess:       hreadyout = pready_m & ~pslverr_m;
            default:        hreadyout = 1'b0;
        endcase
    end

    assign xfer = io_ahb_hsel & io_ahb_hreadyin & hreadyout &
                  ((io_ahb_htrans == HTRANS_NONSEQ) || (io_ahb_htrans == HTRANS_SEQ));

    assign next_xfer = xfer ? (dec_hit ? StSetup : StErr1) : StIdle;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts ACCESS cycles that saw pready low; cleared while in SETUP.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StSetup) begin
            cnt_d = '0;
        end else if ((state_q == StAccess) && !pready_m) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hprot_d  = hprot_q;
        idx_d    = idx_q;
        miss_d   = miss_q;
        pwdata_d = pwdata_q;

        case (state_q)
            StIdle, StErr2: state_d = next_xfer;
            StSetup:        state_d = StAccess;
            StAccess: begin
                if (pready_m) begin
                    state_d = pslverr_m ? StErr1 : next_xfer;
                end else if (timeout) begin
                    state_d = StErr1;
                end
            end
            StErr1:         state_d = StErr2;
            default:        state_d = StIdle;
        endcase

        if (xfer) begin
            haddr_d  = io_ahb_haddr;
            hwrite_d = io_ahb_hwrite;
            hsize_d  = io_ahb_hsize;
            hprot_d  = io_ahb_hprot[1:0];
            idx_d    = dec_idx;
            miss_d   = ~dec_hit;
        end

        // SETUP is the AHB data phase: hold write data for the ACCESS phase.
        if (state_q == StSetup) begin
            pwdata_d = io_ahb_hwdata;
        end

        penable_d = (state_d == StAccess);
        psel_d    = '0;
        if (((state_d == StSetup) || (state_d == StAccess)) && !miss_d) begin
            for (int unsigned i = 0; i < NSLV; i++) begin
                psel_d[i] = (idx_d == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            hprot_q   <= '0;
            idx_q     <= '0;
            miss_q    <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hprot_q   <= hprot_d;
            idx_q     <= idx_d;
            miss_q    <= miss_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign strb_all     = pstrb_gen(hsize_q, haddr_q[2:0], DATA_W == 64);
    assign unused_strb  = ^strb_all;
    assign unused_hprot = ^io_ahb_hprot[3:2];

    assign io_ahb_hreadyout = hreadyout;
    assign io_ahb_hresp     = (state_q == StErr1) || (state_q == StErr2);
    assign io_ahb_hrdata    = (state_q == StAccess) ? prdata_m : '0;

    assign io_apb_paddr   = haddr_q;
    assign io_apb_pwrite  = hwrite_q;
    assign io_apb_penable = penable_q;
    assign io_apb_psel    = psel_q;
    assign io_apb_pwdata  = (state_q == StSetup) ? io_ahb_hwdata : pwdata_q;
    assign io_apb_pstrb   = hwrite_q ? strb_all[STRB_W-1:0] : '0;
    assign io_apb_pprot   = {~hprot_q[0], 1'b0, hprot_q[1]};

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Self-checking bench for ahb_apb_bridge_nslv: directed cases followed by
// randomized transactions, each compared against a transaction-level model.
module tb_ahb_apb_bridge_nslv;
    import ahb_apb_pkg::*;

    localparam int unsigned NSLV   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO     = 8;
`ifdef APB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic [31:0]            haddr;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [1:0]             htrans;
    logic [3:0]             hprot;
    logic [DATA_W-1:0]      hwdata;
    logic                   hsel;
    logic                   hreadyin;
    logic [DATA_W-1:0]      hrdata;
    logic                   hreadyout;
    logic                   hresp;
    logic [31:0]            paddr;
    logic                   pwrite;
    logic                   penable;
    logic [DATA_W-1:0]      pwdata;
    logic [DATA_W/8-1:0]    pstrb;
    logic [2:0]             pprot;
    logic [NSLV-1:0]        psel;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;

    ahb_apb_bridge_nslv #(
        .NSLV        (NSLV),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_ahb_haddr     (haddr),
        .io_ahb_hwrite    (hwrite),
        .io_ahb_hsize     (hsize),
        .io_ahb_htrans    (htrans),
        .io_ahb_hprot     (hprot),
        .io_ahb_hwdata    (hwdata),
        .io_ahb_hsel      (hsel),
        .io_ahb_hreadyin  (hreadyin),
        .io_ahb_hrdata    (hrdata),
        .io_ahb_hreadyout (hreadyout),
        .io_ahb_hresp     (hresp),
        .io_apb_paddr     (paddr),
        .io_apb_pwrite    (pwrite),
        .io_apb_penable   (penable),
        .io_apb_pwdata    (pwdata),
        .io_apb_pstrb     (pstrb),
        .io_apb_pprot     (pprot),
        .io_apb_psel      (psel),
        .io_apb_prdata    (prdata),
        .io_apb_pready    (pready),
        .io_apb_pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        int unsigned tgt;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  prot;
        int unsigned waits;
        bit          slverr;
        logic [1:0]  trans;
    } txn_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Byte lanes covered by the transfer on a 32-bit bus; reads use no lanes.
    function automatic logic [3:0] exp_strb(input txn_t t);
        int unsigned nb;
        int unsigned start;
        logic [3:0]  s;
        s = '0;
        if (t.write) begin
            nb    = 1 << t.size;
            start = int'(t.addr[1:0]);
            for (int unsigned b = 0; b < 4; b++) begin
                if (b >= start && b < start + nb) s[b] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic txn_t mk(input bit hit, input int unsigned tgt, input bit write,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input int unsigned waits,
                                input bit slverr);
        txn_t t;
        t.hit = hit; t.tgt = tgt; t.write = write; t.size = size; t.addr = addr;
        t.wdata = wdata; t.waits = waits; t.slverr = slverr;
        t.prot = 4'($urandom); t.trans = HTRANS_NONSEQ;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t        t;
        int unsigned nb;
        int unsigned f;
        t.hit   = ($urandom_range(0, 5) != 0);
        t.tgt   = $urandom_range(0, NSLV - 1);
        t.write = 1'($urandom_range(0, 1));
        t.size  = 3'($urandom_range(0, 2));
        nb      = 1 << t.size;
        t.addr  = $urandom & ~(nb - 1);
        if (t.hit) begin
            t.addr[31:24] = 8'(32'hF0 + t.tgt);
        end else begin
            f = 32'hF0;
            while (f >= 32'hF0 && f < 32'hF0 + NSLV) f = $urandom_range(0, 255);
            t.addr[31:24] = 8'(f);
        end
        t.wdata  = $urandom;
        t.prot   = 4'($urandom);
        t.waits  = $urandom_range(0, 4);
        t.slverr = ($urandom_range(0, 4) == 0);
        t.trans  = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        return t;
    endfunction

    // Random AHB address-phase noise. With xfer_pat the pattern looks like a
    // real transfer (only legal while the bridge is stalling the bus).
    task automatic ahb_junk(input bit xfer_pat);
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 2));
        hprot  = 4'($urandom);
        hsel     = 1'b1;
        hreadyin = 1'b1;
        htrans   = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        if (!xfer_pat) begin
            case ($urandom_range(0, 2))
                0:       hsel = 1'b0;
                1:       hreadyin = 1'b0;
                default: htrans = ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
            endcase
        end
    endtask

    task automatic drive_slaves(input int unsigned tgt, input bit rdy, input bit err,
                                output logic [DATA_W-1:0] rd);
        for (int unsigned i = 0; i < NSLV; i++) begin
            prdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            pready[i]  = 1'($urandom_range(0, 1));
            pslverr[i] = 1'($urandom_range(0, 1));
        end
        pready[tgt]  = rdy;
        pslverr[tgt] = err;
        rd = prdata[tgt*DATA_W +: DATA_W];
    endtask

    task automatic check_bus(input string tag, input logic [NSLV-1:0] psel_e, input bit pen_e,
                             input bit rdy_e, input bit resp_e, input logic [DATA_W-1:0] rd_e);
        check_eq({tag, " psel"}, 64'(psel), 64'(psel_e));
        check_eq({tag, " penable"}, 64'(penable), 64'(pen_e));
        check_eq({tag, " hreadyout"}, 64'(hreadyout), 64'(rdy_e));
        check_eq({tag, " hresp"}, 64'(hresp), 64'(resp_e));
        check_eq({tag, " hrdata"}, 64'(hrdata), 64'(rd_e));
    endtask

    task automatic check_apb(input string tag, input txn_t t);
        logic [2:0] prot_e;
        prot_e = {~t.prot[0], 1'b0, t.prot[1]};
        check_eq({tag, " paddr"}, 64'(paddr), 64'(t.addr));
        check_eq({tag, " pwrite"}, 64'(pwrite), 64'(t.write));
        check_eq({tag, " pstrb"}, 64'(pstrb), 64'(exp_strb(t)));
        check_eq({tag, " pprot"}, 64'(pprot), 64'(prot_e));
        check_eq({tag, " pwdata"}, 64'(pwdata), 64'(t.wdata));
    endtask

    // Starts in a cycle where the bus is ready (hreadyout expected 1) and
    // returns in the cycle where the transfer's response completes.
    task automatic run_txn(input txn_t t);
        logic [DATA_W-1:0] rd;
        logic [NSLV-1:0]   sel_e;
        bit                abort;
        bit                last;
        bit                rdy;
        bit                err;
        int unsigned       nacc;
        hsel = 1'b1; hreadyin = 1'b1; htrans = t.trans; haddr = t.addr;
        hwrite = t.write; hsize = t.size; hprot = t.prot;
        #1 check_eq("addr phase hreadyout", 64'(hreadyout), 64'd1);
        @(posedge clk); @(negedge clk);
        if (t.hit) begin
            sel_e  = NSLV'(1) << t.tgt;
            hwdata = t.wdata;
            ahb_junk(1'($urandom_range(0, 1)));
            drive_slaves(t.tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
            #1 check_bus("setup", sel_e, 1'b0, 1'b0, 1'b0, '0);
            check_apb("setup", t);
            @(posedge clk); @(negedge clk);
            abort = TimeoutEn && (t.waits >= TO);
            nacc  = abort ? TO : t.waits + 1;
            for (int unsigned c = 0; c < nacc; c++) begin
                last   = (c == nacc - 1);
                rdy    = last && !abort;
                err    = rdy ? t.slverr : 1'($urandom_range(0, 1));
                hwdata = $urandom;
                drive_slaves(t.tgt, rdy, err, rd);
                if (rdy && !err) ahb_junk(1'b0);
                else ahb_junk(1'($urandom_range(0, 1)));
                #1 check_bus("access", sel_e, 1'b1, rdy && !err, 1'b0, rd);
                check_apb("access", t);
                if (rdy && !err) return;
                @(posedge clk); @(negedge clk);
            end
        end
        drive_slaves(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
        ahb_junk(1'($urandom_range(0, 1)));
        #1 check_bus("err1", '0, 1'b0, 1'b0, 1'b1, '0);
        @(posedge clk); @(negedge clk);
        drive_slaves(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
        ahb_junk(1'b0);
        #1 check_bus("err2", '0, 1'b0, 1'b1, 1'b1, '0);
    endtask

    task automatic idle_cycle();
        logic [DATA_W-1:0] rd;
        @(posedge clk); @(negedge clk);
        drive_slaves($urandom_range(0, NSLV - 1), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rd);
        ahb_junk(1'b0);
        #1 check_bus("idle", '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic reset_mid_access();
        logic [DATA_W-1:0] rd;
        hsel = 1'b1; hreadyin = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'hF100_0004;
        hwrite = 1'b1; hsize = HSIZE_WORD; hprot = 4'h3;
        @(posedge clk); @(negedge clk);
        hwdata = $urandom; ahb_junk(1'b0); drive_slaves(1, 1'b0, 1'b0, rd);
        @(posedge clk); @(negedge clk);
        drive_slaves(1, 1'b0, 1'b0, rd); reset = 1'b1;
        #1 check_eq("pre-reset penable", 64'(penable), 64'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; ahb_junk(1'b0); drive_slaves(1, 1'b0, 1'b0, rd);
        #1 check_bus("post-reset", '0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("post-reset paddr", 64'(paddr), 64'd0);
        check_eq("post-reset pstrb", 64'(pstrb), 64'd0);
    endtask

    int unsigned gap;
    logic [DATA_W-1:0] rd0;

    initial begin
        reset = 1'b1; hwdata = '0;
        ahb_junk(1'b0);
        drive_slaves(0, 1'b0, 1'b0, rd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ahb_junk(1'b0);
        #1 check_bus("reset", '0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("reset paddr", 64'(paddr), 64'd0);
        check_eq("reset pstrb", 64'(pstrb), 64'd0);
        check_eq("reset pprot", 64'(pprot), 64'h4);
        check_eq("reset pwdata", 64'(pwdata), 64'd0);

        run_txn(mk(1, 0, 0, HSIZE_WORD, 32'hF000_0010, $urandom, 0, 0));
        idle_cycle();
        run_txn(mk(1, 1, 1, HSIZE_BYTE, 32'hF100_0003, 32'hDEAD_BEEF, 3, 0));
        idle_cycle();
        run_txn(mk(0, 0, 0, HSIZE_WORD, 32'hF200_0000, $urandom, 0, 0));
        idle_cycle();
        run_txn(mk(1, 0, 0, HSIZE_WORD, 32'hF000_0020, $urandom, 0, 1));
        idle_cycle();
        run_txn(mk(1, 0, 1, HSIZE_WORD, 32'hF000_0040, $urandom, 0, 0));
        run_txn(mk(1, 1, 0, HSIZE_HALF, 32'hF100_0002, $urandom, 0, 0));
        idle_cycle();
        run_txn(mk(1, 1, 0, HSIZE_WORD, 32'hF100_0008, $urandom, 12, 0));
        idle_cycle();
        reset_mid_access();

        for (int n = 0; n < 80; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
            run_txn(rand_txn());
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
